// File: rtl/multicycle_seq.sv
// ---------------------------------------------------------------------------
// multicycle_seq
//
// Multi-cycle control sequencer for the LA32R teaching core. Owns the PC, the
// instruction register and the IF/ID/EXE/MEM/WB state machine. Memory
// accesses use a two-phase request/response handshake with variable latency:
// a request is held until addr_ok, then the sequencer waits for data_ok.
// An external decoder looks at `ir` and returns the instruction class and the
// branch outcome. Cycle, retire and stall performance counters are also
// maintained here.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   inst_req          fetch request (IF_REQ)
//   inst_addr         fetch address, always equal to pc
//   inst_addr_ok      fetch request accepted
//   inst_data_ok      fetch data valid, inst_rdata captured into ir
//   ir                instruction register
//   cls_*             decoded instruction class (combinational from ir)
//   br_taken/target   PC redirect, sampled only in the retirement cycle
//   data_req/data_we  data memory request (MEM_REQ) / write flag
//   data_addr_ok      data request accepted
//   data_data_ok      load data valid or store complete
//   rf_we             register-file write strobe (WB with cls_wb)
//   state             current state encoding
//   pc                architectural PC of the current instruction
//   retire            pulse in the last cycle of each instruction
//   cycle_cnt, instret_cnt, stall_cnt   performance counters (wrapping)
// ---------------------------------------------------------------------------
module multicycle_seq #(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 'h1c00_0000,
  parameter int unsigned       CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,

  output logic             inst_req,
  output logic [XLEN-1:0]  inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [31:0]      inst_rdata,
  output logic [31:0]      ir,

  input  logic             cls_nowb_br,
  input  logic             cls_load,
  input  logic             cls_store,
  input  logic             cls_wb,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_target,

  output logic             data_req,
  output logic             data_we,
  input  logic             data_addr_ok,
  input  logic             data_data_ok,

  output logic             rf_we,
  output logic [2:0]       state,
  output logic [XLEN-1:0]  pc,
  output logic             retire,

  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    S_IF_REQ   = 3'd0,
    S_IF_WAIT  = 3'd1,
    S_ID       = 3'd2,
    S_EXE      = 3'd3,
    S_MEM_REQ  = 3'd4,
    S_MEM_WAIT = 3'd5,
    S_WB       = 3'd6,
    S_ILLEGAL  = 3'd7
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   ir_load;
  logic   stall;

  // Next sequential PC. Redirect targets are forced to word alignment; the
  // increment wraps naturally at 2^XLEN.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] cur,
                                              input logic            taken,
                                              input logic [XLEN-1:0] tgt);
    logic [XLEN-1:0] res;
    if (taken) begin
      res = {tgt[XLEN-1:2], 2'b00};
    end else begin
      res = cur + XLEN'(4);
    end
    return res;
  endfunction

  // Wrapping counter increment.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cur);
    return cur + CNT_W'(1);
  endfunction

  // -------------------------------------------------------------------------
  // Next-state / control decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ir_load = 1'b0;
    retire  = 1'b0;
    stall   = 1'b0;

    case (state_q)
      // A stale data_ok here (from an abandoned transaction, or arriving
      // together with addr_ok) must never be taken as the response.
      S_IF_REQ: begin
        if (inst_addr_ok) state_d = S_IF_WAIT;
        else              stall   = 1'b1;
      end

      S_IF_WAIT: begin
        if (inst_data_ok) begin
          ir_load = 1'b1;
          state_d = S_ID;
        end else begin
          stall = 1'b1;
        end
      end

      S_ID: begin
        if (cls_nowb_br) begin
          retire  = 1'b1;
          state_d = S_IF_REQ;
        end else begin
          state_d = S_EXE;
        end
      end

      S_EXE: begin
        if (cls_load || cls_store) state_d = S_MEM_REQ;
        else                       state_d = S_WB;
      end

      S_MEM_REQ: begin
        if (data_addr_ok) state_d = S_MEM_WAIT;
        else              stall   = 1'b1;
      end

      S_MEM_WAIT: begin
        if (data_data_ok) begin
          if (cls_load) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_IF_REQ;
          end
        end else begin
          stall = 1'b1;
        end
      end

      S_WB: begin
        retire  = 1'b1;
        state_d = S_IF_REQ;
      end

      default: begin
        state_d = S_IF_REQ;
      end
    endcase
  end

  // Memory/regfile strobes depend only on the registered state so they are
  // glitch-free with respect to the handshake inputs.
  assign inst_req  = (state_q == S_IF_REQ);
  assign data_req  = (state_q == S_MEM_REQ);
  assign data_we   = (state_q == S_MEM_REQ) && cls_store;
  assign rf_we     = (state_q == S_WB) && cls_wb;
  assign inst_addr = pc;
  assign state     = state_q;

  // -------------------------------------------------------------------------
  // State, architectural registers and counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IF_REQ;
      pc          <= RESET_PC;
      ir          <= '0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      cycle_cnt <= cnt_inc(cycle_cnt);
      if (ir_load) begin
        ir <= inst_rdata;
      end
      if (retire) begin
        pc          <= next_pc(pc, br_taken, br_target);
        instret_cnt <= cnt_inc(instret_cnt);
      end
      if (stall) begin
        stall_cnt <= cnt_inc(stall_cnt);
      end
    end
  end

endmodule

// File: doc/multicycle_seq.md
Name: multicycle_seq

Overview:
Parametrised multi-cycle control sequencer for the LA32R teaching core. Owns the PC, the instruction register and the IF/ID/EXE/MEM/WB state machine. Issues request/handshake transactions to instruction and data memories with variable latency, replacing the single-cycle SRAM assumption. An external decoder and ALU consume `ir` and return instruction class, branch and address information; the block also keeps cycle, retire and stall performance counters.

Parameters:
XLEN, 32, PC/address width (≥ 32).
RESET_PC, 32'h1c00_0000, first fetch address after reset.
CNT_W, 32, width of each performance counter.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
inst_req  out  1  instruction fetch request.
inst_addr  out  XLEN  fetch address; always equals pc.
inst_addr_ok  in  1  fetch request accepted.
inst_data_ok  in  1  fetch data valid.
inst_rdata  in  32  fetched instruction.
ir  out  32  latched instruction register.
cls_nowb_br  in  1  decoded: branch with no writeback (b/beq/bne).
cls_load  in  1  decoded: load.
cls_store  in  1  decoded: store.
cls_wb  in  1  decoded: writes register file.
br_taken  in  1  redirect PC at retirement.
br_target  in  XLEN  redirect target.
data_req  out  1  data memory request.
data_we  out  1  write request; equals cls_store while data_req=1.
data_addr_ok  in  1  data request accepted.
data_data_ok  in  1  data response (load data valid or store done).
rf_we  out  1  register-file write strobe.
state  out  3  current state encoding.
pc  out  XLEN  architectural PC of the current instruction.
retire  out  1  one-cycle pulse when the current instruction completes.
cycle_cnt, instret_cnt, stall_cnt  out  CNT_W  performance counters.

Behaviour:
- State encoding: IF_REQ=0, IF_WAIT=1, ID=2, EXE=3, MEM_REQ=4, MEM_WAIT=5, WB=6. Value 7 is illegal and returns to IF_REQ on the next cycle.
- Reset (sync, takes priority over everything): state=IF_REQ, pc=RESET_PC, ir=0, all counters 0. The first cycle after reset deasserts into IF_REQ with inst_req=1.
- All control outputs are decoded from state: inst_req=(IF_REQ), data_req=(MEM_REQ), rf_we=(WB & cls_wb). retire is asserted on the last cycle of each instruction.
- IF_REQ: hold inst_req=1 until inst_addr_ok=1, then go to IF_WAIT. inst_data_ok is ignored in this state.
- IF_WAIT: on inst_data_ok=1, load ir<=inst_rdata and go to ID. Otherwise stay.
- ID: single cycle. If cls_nowb_br, retire and go to IF_REQ. Otherwise go to EXE.
- EXE: single cycle. If cls_load|cls_store, go to MEM_REQ. Otherwise go to WB.
- MEM_REQ: hold data_req=1 until data_addr_ok=1, then go to MEM_WAIT. data_data_ok is ignored in this state.
- MEM_WAIT: on data_data_ok=1, go to WB if cls_load. For a store, retire and go to IF_REQ.
- WB: single cycle, rf_we=cls_wb, retire, go to IF_REQ.
- Retirement cycle:
  - pc <= br_taken ? {br_target[XLEN-1:2],2'b00} : pc+4, modulo 2^XLEN. A misaligned target is silently aligned.
  - br_taken is sampled only in that cycle.
- The decoder must hold class inputs stable from ID through retirement; they are combinational functions of ir.
- Latency:
  - Non-memory ALU op: 5 cycles (1 IF_REQ + 1 IF_WAIT + ID + EXE + WB) with zero-wait memory, i.e. addr_ok in the first IF_REQ cycle and data_ok in the first IF_WAIT cycle.
  - nowb branch: 3 cycles.
  - Store: 6 cycles.
  - Load: 7 cycles.
- Counters, each wrapping modulo 2^CNT_W:
  - cycle_cnt increments every non-reset cycle.
  - instret_cnt increments on retire.
  - stall_cnt increments on any cycle in IF_REQ/MEM_REQ without addr_ok, or in IF_WAIT/MEM_WAIT without data_ok.
- Reset mid-transaction: the outstanding request is abandoned and memories are reset with the core. A stale data_ok arriving in a REQ state is ignored.
- Simultaneous addr_ok and data_ok in a REQ state: only addr_ok is honoured. Responses arrive at least one cycle after acceptance.

Test Plan:
1. Zero-wait memory, add.w at 0x1c000000 (cls_wb=1) → states 0,1,2,3,6. rf_we=1 only in cycle 5, retire in cycle 5, pc=0x1c000004 afterwards, instret_cnt=1, stall_cnt=0.
2. inst_addr_ok delayed 3 cycles, then inst_data_ok delayed 2 cycles → inst_req held 4 cycles, stall_cnt=5, ir captured only on the data_ok cycle.
3. beq with br_taken=1, br_target=0x1c000103 → 3-cycle instruction, rf_we never asserted, pc=0x1c000100.
4. ld.w with data_addr_ok after 1 wait and data_data_ok after 2 waits → data_we=0, states 4,4,5,5,5,6. rf_we pulses once, total 10 cycles.
5. st.w zero-wait → data_we=1 while data_req=1, no WB state, retire from MEM_WAIT, pc+4.
6. Assert reset while in MEM_WAIT → next cycle state=0, pc=RESET_PC, counters 0, data_req=0. A stale data_data_ok injected in IF_REQ causes no transition.
